shark_collision: RTL

- Sits directly downstream of the shark sprite block and consumes its `shark_x`/`shark_y` top-left position, together with Yoshi's `y_x`/`y_y`.
- Once per video frame, during vertical blank, it tests the two 16x16 bounding boxes for overlap.
- On a hit it decrements a lives counter and runs an invulnerability window with a blink flag.
- It raises `game_over` when lives reach zero. Outputs feed the scoreboard/HUD and the top-level pixel mux.

---
 rtl/game_pkg.sv | 20 ++
 rtl/bbox_overlap.sv | 25 ++
 rtl/shark_collision.sv | 113 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants and the collision-FSM state encoding, reused by every
// enemy collision block.
package game_pkg;

  localparam int MAX_X    = 640;
  localparam int MAX_Y    = 480;
  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;

  localparam logic [1:0] S_PLAY   = 2'd0;
  localparam logic [1:0] S_INVULN = 2'd1;
  localparam logic [1:0] S_OVER   = 2'd2;

  typedef enum logic [1:0] {
    ST_PLAY   = S_PLAY,
    ST_INVULN = S_INVULN,
    ST_OVER   = S_OVER
  } coll_state_t;

endpackage

// File: rtl/bbox_overlap.sv
// Combinational axis-aligned overlap test between two WxH boxes given by
// top-left corners. Touching edges do not count as overlap.
module bbox_overlap #(
  parameter int W = 16,
  parameter int H = 16
) (
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  output logic       ovl
);

  // One extra bit so corner+size never wraps near the 10-bit limit.
  logic [10:0] ax_e, ay_e, bx_e, by_e;

  assign ax_e = {1'b0, ax};
  assign ay_e = {1'b0, ay};
  assign bx_e = {1'b0, bx};
  assign by_e = {1'b0, by};

  assign ovl = (ax_e < bx_e + 11'(W)) && (bx_e < ax_e + 11'(W)) &&
               (ay_e < by_e + 11'(H)) && (by_e < ay_e + 11'(H));

endmodule

// File: rtl/shark_collision.sv
// Once-per-frame shark/Yoshi collision check with lives, invulnerability
// window and game-over handling.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_PLAY   | vulnerable; overlap tested on each frame tick
// ST_INVULN | post-hit grace; frame_cnt counts ticks down to 0
// ST_OVER   | no lives left; waits for restart
import game_pkg::*;

module shark_collision #(
  parameter int SPRITE_W      = game_pkg::SPRITE_W,
  parameter int SPRITE_H      = game_pkg::SPRITE_H,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int FRAME_Y       = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] y_x,
  input  logic [9:0] y_y,
  input  logic [9:0] shark_x,
  input  logic [9:0] shark_y,
  input  logic       restart,
  output logic       hit,
  output logic [2:0] lives,
  output logic       invuln,
  output logic       blink,
  output logic       game_over
);

  localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);
  localparam logic [7:0] FC_LOAD    = 8'(INVULN_FRAMES - 1);

  coll_state_t state;
  logic [7:0]  frame_cnt;
  logic [7:0]  frame_dec;
  logic        match, match_d, tick, ovl;

  bbox_overlap #(.W(SPRITE_W), .H(SPRITE_H)) u_bbox (
    .ax  (y_x),
    .ay  (y_y),
    .bx  (shark_x),
    .by  (shark_y),
    .ovl (ovl)
  );

  // x/y hold for several clocks per pixel; the edge of match gives one tick per frame.
  assign match     = (x == 10'd0) && (y == 10'(FRAME_Y));
  assign tick      = match && !match_d;
  assign frame_dec = frame_cnt - 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_PLAY;
      lives     <= LIVES_LOAD;
      frame_cnt <= 8'd0;
      match_d   <= 1'b0;
      hit       <= 1'b0;
      invuln    <= 1'b0;
      blink     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      match_d <= match;
      hit     <= 1'b0;
      case (state)
        ST_PLAY: begin
          if (tick && ovl) begin
            hit <= 1'b1;
            if (lives > 3'd1) begin
              lives     <= lives - 3'd1;
              frame_cnt <= FC_LOAD;
              invuln    <= 1'b1;
              blink     <= FC_LOAD[2];
              state     <= ST_INVULN;
            end else begin
              lives     <= 3'd0;
              game_over <= 1'b1;
              state     <= ST_OVER;
            end
          end
        end
        ST_INVULN: begin
          if (tick) begin
            if (frame_cnt == 8'd0) begin
              invuln <= 1'b0;
              blink  <= 1'b0;
              state  <= ST_PLAY;
            end else begin
              frame_cnt <= frame_dec;
              blink     <= frame_dec[2];
            end
          end
        end
        ST_OVER: begin
          // restart is level-sensitive here and takes priority over any tick
          if (restart) begin
            lives     <= LIVES_LOAD;
            frame_cnt <= 8'd0;
            game_over <= 1'b0;
            state     <= ST_PLAY;
          end else begin
            lives <= 3'd0;
          end
        end
        default: state <= ST_PLAY;
      endcase
    end
  end

endmodule
